trena_relatorio_auto: RTL

Parametrised measure-and-report sequencer for the ultrasonic rangefinder. It triggers measurements on demand or periodically, and waits for the BCD result with a timeout. It then streams DIGITS ASCII characters plus a terminator to an external 7O1 serial transmitter over a start/ready handshake. It sits between the HC-SR04 interface and tx_serial_7O1, replacing the external sequencing FSM, fixed 3-digit mux and fixed 1 s timer.

---
 rtl/trena_relatorio_auto_pkg.sv | 30 +++
 rtl/contador_m.sv | 30 +++
 rtl/trena_relatorio_auto.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/trena_relatorio_auto_pkg.sv
// Shared definitions for the rangefinder measure-and-report sequencer:
// FSM state codes, ASCII digit prefix and default framing characters.
package trena_relatorio_auto_pkg;

  // State codes are visible on db_estado, so their values are fixed.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    PEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    ARMAZENA       = 4'd4,
    PREPARA        = 4'd5,
    ENVIA          = 4'd6,
    AGUARDA_TX     = 4'd7,
    FINAL          = 4'd8
  } estado_t;

  // '0'..'9' are 7'b011_0000..7'b011_1001: prefix followed by the BCD nibble.
  localparam logic [2:0] ASCII_DIGIT_PREFIX = 3'b011;

  localparam logic [6:0] TERM_DEFAULT     = 7'h23;  // '#'
  localparam logic [6:0] ERR_CHAR_DEFAULT = 7'h3F;  // '?'

  // Converts one BCD nibble to ASCII; anything above 9 is not a digit.
  function automatic logic [6:0] ascii_digito(input logic [3:0] nibble,
                                              input logic [6:0] err_char);
    return (nibble <= 4'd9) ? {ASCII_DIGIT_PREFIX, nibble} : err_char;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter: counts 0..M-1 while conta=1 and wraps; zera clears it
// synchronously. fim flags the terminal count M-1.
module contador_m #(
  parameter int M = 100,
  parameter int N = $clog2(M)
) (
  input  logic clock,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] q;

  // Count register: clear has priority over counting, wrap at M-1.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == ULTIMO) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == ULTIMO);

endmodule

// File: rtl/trena_relatorio_auto.sv
// Measure-and-report sequencer: triggers the HC-SR04 interface on demand or
// periodically, waits for the BCD result (with timeout) and streams the
// digits plus a terminator to the 7O1 serial transmitter.
module trena_relatorio_auto
  import trena_relatorio_auto_pkg::*;
#(
  parameter int         DIGITS   = 3,
  parameter int         PERIOD   = 50000000,
  parameter int         TIMEOUT  = 2000000,
  parameter logic [6:0] TERM     = TERM_DEFAULT,
  parameter logic [6:0] ERR_CHAR = ERR_CHAR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mensurar,
  input  logic                  modo_auto,
  input  logic                  medida_pronto,
  input  logic [4*DIGITS-1:0]   medida,
  input  logic                  tx_pronto,
  output logic                  medir,
  output logic                  tx_partida,
  output logic [6:0]            tx_dados,
  output logic [4*DIGITS-1:0]   distancia,
  output logic                  erro_timeout,
  output logic                  pronto,
  output logic [3:0]            db_estado
);

  localparam int               IDX_W    = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] IDX_TERM = IDX_W'(DIGITS);

  estado_t          estado;
  logic [IDX_W-1:0] idx;
  logic             pendente;
  logic             fim_timer;
  logic             fim_timeout;
  logic             tick;
  logic             pede_medida;
  logic [3:0]       nibble;
  logic [6:0]       caractere;

  // Auto timer: held at zero whenever periodic mode is off.
  contador_m #(.M(PERIOD)) u_timer (
    .clock (clock),
    .zera  (reset | ~modo_auto),
    .conta (modo_auto),
    .fim   (fim_timer)
  );

  // Timeout counter: cleared while triggering, runs only while waiting.
  contador_m #(.M(TIMEOUT)) u_timeout (
    .clock (clock),
    .zera  (reset | (estado == PEDE)),
    .conta (estado == AGUARDA_MEDIDA),
    .fim   (fim_timeout)
  );

  assign tick        = modo_auto & fim_timer;
  assign pede_medida = mensurar | pendente | tick;
  assign db_estado   = estado;

  // One-deep auto request: set by a tick, consumed when ESPERA starts a
  // measurement, dropped entirely when periodic mode is switched off.
  always_ff @(posedge clock) begin
    if (reset || !modo_auto) begin
      pendente <= 1'b0;
    end else if ((estado == ESPERA) && pede_medida) begin
      pendente <= 1'b0;
    end else if (tick) begin
      pendente <= 1'b1;
    end
  end

  // Character for the current index: MS digit first, then the terminator.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    nibble    = '0;
    caractere = TERM;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble = distancia[4*(DIGITS-1-i) +: 4];
      end
    end
    if (idx != IDX_TERM) begin
      caractere = erro_timeout ? ERR_CHAR : ascii_digito(nibble, ERR_CHAR);
    end
  end

  // Sequencer FSM with registered pulse outputs, asserted on entry to the
  // state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INICIAL;
      idx          <= '0;
      distancia    <= '0;
      erro_timeout <= 1'b0;
      medir        <= 1'b0;
      tx_partida   <= 1'b0;
      pronto       <= 1'b0;
      tx_dados     <= TERM;
    end else begin
      medir      <= 1'b0;
      tx_partida <= 1'b0;
      pronto     <= 1'b0;
      case (estado)
        INICIAL: estado <= ESPERA;
        ESPERA: begin
          if (pede_medida) begin
            medir  <= 1'b1;
            estado <= PEDE;
          end
        end
        PEDE: begin
          // Timeout path skips ARMAZENA, so the index is cleared here too.
          idx    <= '0;
          estado <= AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          if (medida_pronto) begin
            estado <= ARMAZENA;
          end else if (fim_timeout) begin
            erro_timeout <= 1'b1;
            estado       <= PREPARA;
          end
        end
        ARMAZENA: begin
          distancia    <= medida;
          erro_timeout <= 1'b0;
          idx          <= '0;
          estado       <= PREPARA;
        end
        PREPARA: begin
          tx_dados   <= caractere;
          tx_partida <= 1'b1;
          estado     <= ENVIA;
        end
        ENVIA: estado <= AGUARDA_TX;
        AGUARDA_TX: begin
          if (tx_pronto) begin
            if (idx == IDX_TERM) begin
              pronto <= 1'b1;
              estado <= FINAL;
            end else begin
              idx    <= idx + 1'b1;
              estado <= PREPARA;
            end
          end
        end
        FINAL:   estado <= ESPERA;
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule
